// File: rtl/xdma_write_req_arbiter_pkg.sv
// Shared types for the xDMA write-request arbiter: descriptor layout,
// requester index enum and arbiter FSM state.
package xdma_write_req_arbiter_pkg;

    typedef struct packed {
        logic [3:0]  dma_id;
        logic        dma_type;
        logic [31:0] remote_addr;
        logic [15:0] dma_length;
        logic        ready_to_transfer;
    } xdma_req_desc_t;

    localparam int DescWidth = $bits(xdma_req_desc_t);

    typedef enum logic [1:0] {
        ToRemoteData  = 2'd0,
        ToRemoteCfg   = 2'd1,
        ToRemoteGrant = 2'd2
    } xdma_req_idx_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/xdma_write_req_arbiter_rr_pick.sv
// Round-robin picker: rotate the valid vector by the pointer, find the first
// set bit (trailing-zero count), then un-rotate back to a requester index.
module xdma_write_req_arbiter_rr_pick #(
    parameter int NumReq   = 3,
    parameter int IdxWidth = 2
) (
    input  logic [NumReq-1:0]   valid,
    input  logic [IdxWidth-1:0] ptr,
    output logic [IdxWidth-1:0] gnt_idx,
    output logic                any_valid
);

    logic [NumReq-1:0] rot;
    int                cnt;
    int                j;
    int                k;
    logic              found;

    always_comb begin
        rot   = '0;
        cnt   = 0;
        j     = 0;
        k     = 0;
        found = 1'b0;
        for (int i = 0; i < NumReq; i++) begin
            j = i + int'(ptr);
            if (j >= NumReq) j = j - NumReq;
            rot[i] = valid[j];
        end
        for (int i = 0; i < NumReq; i++) begin
            if (!found && rot[i]) begin
                cnt   = i;
                found = 1'b1;
            end
        end
        k = cnt + int'(ptr);
        if (k >= NumReq) k = k - NumReq;
        gnt_idx   = IdxWidth'(k);
        any_valid = |valid;
    end

endmodule

// File: rtl/xdma_write_req_arbiter.sv
// Shares the single burst-reshaper write-request path between NumReq requesters;
// holds the granted descriptor stable and re-arbitrates only after write_req_done_i.
module xdma_write_req_arbiter
    import xdma_write_req_arbiter_pkg::*;
#(
    parameter int NumReq = 3,
    localparam int IdxWidth = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NumReq*DescWidth-1:0] req_desc_i,
    input  logic [NumReq-1:0]           req_valid_i,
    output logic [NumReq-1:0]           req_ready_o,
    output logic [DescWidth-1:0]        write_req_desc_o,
    output logic [IdxWidth-1:0]         write_req_idx_o,
    output logic                        write_req_desc_valid_o,
    input  logic                        write_req_done_i,
    output logic                        done_o,
    output logic [IdxWidth-1:0]         done_idx_o,
    output logic                        busy_o
);

    state_t                state;
    logic [DescWidth-1:0]  desc_q;
    logic [IdxWidth-1:0]   idx_q;
    logic [IdxWidth-1:0]   rr_ptr;
    logic [IdxWidth-1:0]   rr_ptr_next;
    logic [IdxWidth-1:0]   done_idx_q;
    logic [IdxWidth-1:0]   gnt_idx;
    logic                  any_valid;
    logic                  pulse_q;
    logic                  done_q;
    xdma_req_desc_t        gnt_desc;

    xdma_write_req_arbiter_rr_pick #(
        .NumReq   (NumReq),
        .IdxWidth (IdxWidth)
    ) i_rr_pick (
        .valid     (req_valid_i),
        .ptr       (rr_ptr),
        .gnt_idx   (gnt_idx),
        .any_valid (any_valid)
    );

    always_comb begin
        gnt_desc = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (IdxWidth'(i) == gnt_idx) gnt_desc = req_desc_i[i*DescWidth +: DescWidth];
        end
        rr_ptr_next = (gnt_idx == IdxWidth'(NumReq - 1)) ? '0 : gnt_idx + 1'b1;
    end

    // Ready is combinational from valid so the accept lands in the capture cycle;
    // gating with rst_ni keeps every output low while reset is held.
    always_comb begin
        req_ready_o = '0;
        if (rst_ni && state == IDLE && any_valid) req_ready_o[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            desc_q     <= '0;
            idx_q      <= '0;
            rr_ptr     <= '0;
            pulse_q    <= 1'b0;
            done_q     <= 1'b0;
            done_idx_q <= '0;
        end else begin
            pulse_q <= 1'b0;
            done_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        desc_q <= gnt_desc;
                        idx_q  <= gnt_idx;
                        rr_ptr <= rr_ptr_next;
                        // A zero-length request completes locally: the reshaper would see len-1 = -1.
                        if (gnt_desc.dma_length == '0) begin
                            done_q     <= 1'b1;
                            done_idx_q <= gnt_idx;
                        end else begin
                            state   <= ISSUE;
                            pulse_q <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (write_req_done_i) begin
                        done_q     <= 1'b1;
                        done_idx_q <= idx_q;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign write_req_desc_o       = desc_q;
    assign write_req_idx_o        = idx_q;
    assign write_req_desc_valid_o = pulse_q;
    assign done_o                 = done_q;
    assign done_idx_o             = done_idx_q;
    assign busy_o                 = (state != IDLE);

endmodule
